imm_gen_pipe: RTL and testbench

Registered, flow-controlled immediate generator for the decode stage. Decodes every RV32I immediate format (I, S, B, U, J, plus R/no-immediate) from a 32-bit instruction, sign-extends to a parametrised datapath width, and passes a caller tag alongside. A 2-entry buffer with valid/ready handshakes on both sides decouples fetch from the register-read stage. Adds a flush input, an illegal-opcode flag and a saturating illegal-instruction counter.

---
 rtl/imm_gen_pipe.sv | 123 ++++++++++++
 tb/tb_imm_gen_pipe.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/imm_gen_pipe.sv
// rtl/imm_gen_pipe.sv - RV32I immediate decoder feeding a 2-entry valid/ready buffer
module imm_gen_pipe #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [2:0]       out_fmt,
    output logic             out_illegal,
    output logic [TAG_W-1:0] out_tag,
    output logic [15:0]      ill_count
);

    logic [31:0]      imm32;
    logic [XLEN-1:0]  dec_imm;
    logic [2:0]       dec_fmt;
    logic             dec_ill;

    // Every supported opcode ends in 2'b11, so a non-11 low pair falls into default.
    always_comb begin
        imm32   = '0;
        dec_fmt = 3'd7;
        dec_ill = 1'b1;
        case (in_instr[6:0])
            7'b0000011, 7'b0010011, 7'b1100111, 7'b1110011, 7'b0001111: begin
                imm32   = {{20{in_instr[31]}}, in_instr[31:20]};
                dec_fmt = 3'd1;
                dec_ill = 1'b0;
            end
            7'b0100011: begin
                imm32   = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
                dec_fmt = 3'd2;
                dec_ill = 1'b0;
            end
            7'b1100011: begin
                imm32   = {{20{in_instr[31]}}, in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
                dec_fmt = 3'd3;
                dec_ill = 1'b0;
            end
            7'b0110111, 7'b0010111: begin
                imm32   = {in_instr[31:12], 12'b0};
                dec_fmt = 3'd4;
                dec_ill = 1'b0;
            end
            7'b1101111: begin
                imm32   = {{12{in_instr[31]}}, in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};
                dec_fmt = 3'd5;
                dec_ill = 1'b0;
            end
            7'b0110011: begin
                dec_fmt = 3'd0;
                dec_ill = 1'b0;
            end
            default: ;
        endcase
    end

    // imm32[31] equals instr[31] for every non-zero immediate, so widening it sign-extends correctly.
    assign dec_imm = XLEN'($signed(imm32));

    logic [XLEN-1:0]  imm_q [2];
    logic [2:0]       fmt_q [2];
    logic             ill_q [2];
    logic [TAG_W-1:0] tag_q [2];
    logic [1:0]       count;
    logic             push;
    logic             pop;

    assign in_ready  = !reset && !flush && (count != 2'd2);
    assign out_valid = (count != 2'd0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    assign out_imm     = out_valid ? imm_q[0] : '0;
    assign out_fmt     = out_valid ? fmt_q[0] : '0;
    assign out_illegal = out_valid ? ill_q[0] : 1'b0;
    assign out_tag     = out_valid ? tag_q[0] : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            count     <= 2'd0;
            ill_count <= 16'd0;
        end else if (flush) begin
            count <= 2'd0;
        end else begin
            if (pop) begin
                imm_q[0] <= imm_q[1];
                fmt_q[0] <= fmt_q[1];
                ill_q[0] <= ill_q[1];
                tag_q[0] <= tag_q[1];
            end
            // Slot for the new entry is the one just past the post-pop tail.
            if (push) begin
                if ((count == 2'd0) || (count == 2'd1 && pop)) begin
                    imm_q[0] <= dec_imm;
                    fmt_q[0] <= dec_fmt;
                    ill_q[0] <= dec_ill;
                    tag_q[0] <= in_tag;
                end else begin
                    imm_q[1] <= dec_imm;
                    fmt_q[1] <= dec_fmt;
                    ill_q[1] <= dec_ill;
                    tag_q[1] <= in_tag;
                end
            end
            if (push && !pop)
                count <= count + 2'd1;
            else if (pop && !push)
                count <= count - 2'd1;
            if (push && dec_ill && ill_count != 16'hFFFF)
                ill_count <= ill_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb/tb_imm_gen_pipe.sv - vector table, corner sequences and random run against a queue model
module tb_imm_gen_pipe;

    logic        clk = 1'b0;
    logic        reset, flush, in_valid, out_ready;
    logic [31:0] in_instr;
    logic [4:0]  in_tag;
    logic        in_ready, out_valid, out_illegal;
    logic [31:0] out_imm;
    logic [2:0]  out_fmt;
    logic [4:0]  out_tag;
    logic [15:0] ill_count;
    logic        in_ready64, out_valid64, out_illegal64;
    logic [63:0] out_imm64;
    logic [2:0]  out_fmt64;
    logic [4:0]  out_tag64;
    logic [15:0] ill_count64;

    always #5 clk = ~clk;

    imm_gen_pipe #(.XLEN(32), .TAG_W(5)) dut (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready),
        .out_imm(out_imm), .out_fmt(out_fmt), .out_illegal(out_illegal), .out_tag(out_tag),
        .ill_count(ill_count));

    imm_gen_pipe #(.XLEN(64), .TAG_W(5)) dut64 (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready64),
        .in_instr(in_instr), .in_tag(in_tag), .out_valid(out_valid64), .out_ready(out_ready),
        .out_imm(out_imm64), .out_fmt(out_fmt64), .out_illegal(out_illegal64), .out_tag(out_tag64),
        .ill_count(ill_count64));

    typedef struct {
        logic [63:0] imm;
        logic [2:0]  fmt;
        logic        ill;
        logic [4:0]  tag;
    } ent_t;

    typedef struct {
        logic [31:0] instr;
        logic [63:0] imm;
        logic [2:0]  fmt;
        logic        ill;
    } vec_t;

    ent_t mq[$];
    int   m_ill;
    int   total = 0;
    int   bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic ent_t ref_dec(input logic [31:0] i, input logic [4:0] tg);
        ent_t   e;
        int     s;
        longint v;
        s = $signed(i);
        v = 0;
        e.tag = tg;
        e.ill = 1'b0;
        if (i[6:0] inside {7'h03, 7'h13, 7'h67, 7'h73, 7'h0F}) begin
            e.fmt = 3'd1;
            v = longint'(s >>> 20);
        end else if (i[6:0] == 7'h23) begin
            e.fmt = 3'd2;
            v = longint'(s >>> 25) * 32 + longint'(i[11:7]);
        end else if (i[6:0] == 7'h63) begin
            e.fmt = 3'd3;
            v = longint'(s >>> 31) * 4096 + longint'(i[7]) * 2048
              + longint'(i[30:25]) * 32 + longint'(i[11:8]) * 2;
        end else if (i[6:0] inside {7'h37, 7'h17}) begin
            e.fmt = 3'd4;
            v = longint'(s >>> 12) * 4096;
        end else if (i[6:0] == 7'h6F) begin
            e.fmt = 3'd5;
            v = longint'(s >>> 31) * 1048576 + longint'(i[19:12]) * 4096
              + longint'(i[20]) * 2048 + longint'(i[30:21]) * 2;
        end else if (i[6:0] == 7'h33) begin
            e.fmt = 3'd0;
        end else begin
            e.fmt = 3'd7;
            e.ill = 1'b1;
        end
        e.imm = v;
        return e;
    endfunction

    task automatic check_outputs();
        ent_t h;
        h = '{imm: 64'd0, fmt: 3'd0, ill: 1'b0, tag: 5'd0};
        if (mq.size() != 0) h = mq[0];
        check("out_valid", out_valid, mq.size() != 0);
        check("out_imm", out_imm, {32'd0, h.imm[31:0]});
        check("out_imm64", out_imm64, h.imm);
        check("out_fmt", out_fmt, h.fmt);
        check("out_illegal", out_illegal, h.ill);
        check("out_tag", out_tag, h.tag);
        check("ill_count", ill_count, m_ill);
    endtask

    task automatic step(input bit v, input logic [31:0] ins, input logic [4:0] tg,
                        input bit ordy, input bit fl, input bit rst);
        bit exp_rdy, push, pop;
        ent_t e;
        in_valid  = v;
        in_instr  = ins;
        in_tag    = tg;
        out_ready = ordy;
        flush     = fl;
        reset     = rst;
        #1;
        exp_rdy = !rst && !fl && (mq.size() != 2);
        check("in_ready", in_ready, exp_rdy);
        push = v && exp_rdy;
        pop  = (mq.size() != 0) && ordy;
        e = ref_dec(ins, tg);
        @(posedge clk);
        #1;
        if (rst) begin
            mq.delete();
            m_ill = 0;
        end else if (fl) begin
            mq.delete();
        end else begin
            if (pop) void'(mq.pop_front());
            if (push) begin
                mq.push_back(e);
                if (e.ill && m_ill < 65535) m_ill++;
            end
        end
        check_outputs();
    endtask

    vec_t tbl[12];

    initial begin
        int          held;
        int          exp_ill;
        logic [31:0] r;
        logic [6:0]  ops[14];

        tbl[0]  = '{32'hFFF00093, 64'hFFFFFFFF_FFFFFFFF, 3'd1, 1'b0};
        tbl[1]  = '{32'hFE112E23, 64'hFFFFFFFF_FFFFFFFC, 3'd2, 1'b0};
        tbl[2]  = '{32'hFE000CE3, 64'hFFFFFFFF_FFFFFFF8, 3'd3, 1'b0};
        tbl[3]  = '{32'h0010006F, 64'h00000000_00000800, 3'd5, 1'b0};
        tbl[4]  = '{32'h800002B7, 64'hFFFFFFFF_80000000, 3'd4, 1'b0};
        tbl[5]  = '{32'h00000000, 64'h0,                 3'd7, 1'b1};
        tbl[6]  = '{32'h00000033, 64'h0,                 3'd0, 1'b0};
        tbl[7]  = '{32'h00A00513, 64'h00000000_0000000A, 3'd1, 1'b0};
        tbl[8]  = '{32'h80000073, 64'hFFFFFFFF_FFFFF800, 3'd1, 1'b0};
        tbl[9]  = '{32'hFFFFF017, 64'hFFFFFFFF_FFFFF000, 3'd4, 1'b0};
        tbl[10] = '{32'h0000007F, 64'h0,                 3'd7, 1'b1};
        tbl[11] = '{32'hFFFFFFFC, 64'h0,                 3'd7, 1'b1};

        ops = '{7'h03, 7'h13, 7'h67, 7'h73, 7'h0F, 7'h23, 7'h63,
                7'h37, 7'h17, 7'h6F, 7'h33, 7'h00, 7'h7F, 7'h5B};

        m_ill = 0;
        step(0, 32'h0, 5'd0, 0, 0, 1);
        step(0, 32'h0, 5'd0, 0, 0, 1);
        check("reset_out_valid", out_valid, 1'b0);
        check("reset_ill_count", ill_count, 16'd0);

        exp_ill = 0;
        for (int i = 0; i < 12; i++) begin
            step(1, tbl[i].instr, 5'(i + 3), 1, 0, 0);
            if (tbl[i].ill) exp_ill++;
            check("vec_imm32", out_imm, {32'd0, tbl[i].imm[31:0]});
            check("vec_imm64", out_imm64, tbl[i].imm);
            check("vec_fmt", out_fmt, tbl[i].fmt);
            check("vec_illegal", out_illegal, tbl[i].ill);
            check("vec_tag", out_tag, 5'(i + 3));
            check("vec_ill_count", ill_count, exp_ill);
        end
        step(0, 32'h0, 5'd0, 1, 0, 0);
        check("drained", out_valid, 1'b0);

        step(1, 32'h00100093, 5'd10, 0, 0, 0);
        step(1, 32'h00200093, 5'd11, 0, 0, 0);
        step(1, 32'h00300093, 5'd12, 0, 0, 0);
        check("bp_full_ready", in_ready, 1'b0);
        check("bp_head_tag", out_tag, 5'd10);
        step(1, 32'h00300093, 5'd12, 1, 0, 0);
        check("bp_second_tag", out_tag, 5'd11);
        check("bp_reopen_ready", in_ready, 1'b1);
        step(1, 32'h00300093, 5'd12, 1, 0, 0);
        check("bp_third_tag", out_tag, 5'd12);
        check("bp_third_imm", out_imm, 32'd3);
        step(0, 32'h0, 5'd0, 1, 0, 0);

        step(1, 32'h00000013, 5'd1, 0, 0, 0);
        step(1, 32'h00000013, 5'd2, 0, 0, 0);
        held = ill_count;
        step(1, 32'h00000000, 5'd3, 0, 1, 0);
        check("flush_valid", out_valid, 1'b0);
        check("flush_ill_kept", ill_count, held);
        step(0, 32'h0, 5'd0, 1, 0, 0);
        check("flush_lost", out_valid, 1'b0);

        step(1, 32'h00000000, 5'd7, 0, 0, 0);
        step(1, 32'hFFF00093, 5'd8, 0, 0, 1);
        check("mid_reset_valid", out_valid, 1'b0);
        check("mid_reset_tag", out_tag, 5'd0);
        check("mid_reset_ill", ill_count, 16'd0);

        for (int n = 0; n < 600; n++) begin
            r = $urandom;
            if ($urandom_range(0, 9) != 0) r[6:0] = ops[$urandom_range(0, 13)];
            step($urandom_range(0, 3) != 0, r, 5'($urandom), $urandom_range(0, 2) != 0,
                 $urandom_range(0, 24) == 0, $urandom_range(0, 79) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
